// File: rtl/ball_motion.sv
// ball_motion: per-frame ball stepper with brick/wall/paddle reflection and lost-ball detection
module ball_motion #(
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 159,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 119,
    parameter int X_START       = 80,
    parameter int Y_START       = 100,
    parameter int PADDLE_Y      = 110,
    parameter int PADDLE_W      = 16,
    parameter int CHECK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frameTick,
    input  logic       gameEnable,
    input  logic [7:0] x_paddle,
    output logic       ballcheckReset,
    output logic       ballcheckEnable,
    input  logic       ballcheckEnd,
    input  logic       brickBallCollide,
    input  logic [2:0] collideDir,
    output logic [7:0] x_ball,
    output logic [7:0] y_ball,
    output logic       moveDone,
    output logic       ballLost
);
    localparam int CW = $clog2(CHECK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CRST, CHECK, REFLECT, MOVE, LOST} state_t;

    state_t          state;
    logic            dx_neg, dy_neg, hit;
    logic [2:0]      hit_dir;
    logic [CW-1:0]   cnt;
    logic            tog_x, tog_y, dx_b, dy_b, dx_r, dy_w, dy_r, on_paddle, lose;

    always_comb begin
        tog_x     = hit && (hit_dir == 3'd3 || hit_dir == 3'd4 || hit_dir >= 3'd5);
        tog_y     = hit && (hit_dir == 3'd1 || hit_dir == 3'd2 || hit_dir >= 3'd5);
        dx_b      = dx_neg ^ tog_x;
        dy_b      = dy_neg ^ tog_y;
        dx_r      = (x_ball == 8'(X_MIN)) ? 1'b0 : (x_ball == 8'(X_MAX)) ? 1'b1 : dx_b;
        dy_w      = (y_ball == 8'(Y_MIN)) ? 1'b0 : dy_b;
        on_paddle = {1'b0, x_ball} >= {1'b0, x_paddle} &&
                    {1'b0, x_ball} <= {1'b0, x_paddle} + 9'(PADDLE_W - 1);
        dy_r      = (!dy_w && {1'b0, y_ball} + 9'd1 == 9'(PADDLE_Y) && on_paddle) ? 1'b1 : dy_w;
        lose      = !dy_r && y_ball == 8'(Y_MAX - 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            x_ball          <= 8'(X_START);
            y_ball          <= 8'(Y_START);
            dx_neg          <= 1'b0;
            dy_neg          <= 1'b1;
            hit             <= 1'b0;
            hit_dir         <= 3'd0;
            cnt             <= '0;
            ballcheckReset  <= 1'b0;
            ballcheckEnable <= 1'b0;
            moveDone        <= 1'b0;
            ballLost        <= 1'b0;
        end else begin
            ballcheckReset <= 1'b0;
            moveDone       <= 1'b0;
            case (state)
                IDLE: if (frameTick && gameEnable) begin
                    state          <= CRST;
                    ballcheckReset <= 1'b1;
                end
                CRST: begin
                    hit             <= 1'b0;
                    cnt             <= '0;
                    ballcheckEnable <= 1'b1;
                    state           <= CHECK;
                end
                CHECK: begin
                    cnt <= cnt + 1'b1;
                    if (brickBallCollide && !hit) begin
                        hit     <= 1'b1;
                        hit_dir <= collideDir;
                    end
                    if (ballcheckEnd || cnt == CW'(CHECK_TIMEOUT - 1)) begin
                        ballcheckEnable <= 1'b0;
                        state           <= REFLECT;
                        if (!ballcheckEnd) hit <= 1'b0;
                    end
                end
                REFLECT: begin
                    dx_neg   <= dx_r;
                    dy_neg   <= dy_r;
                    ballLost <= lose;
                    state    <= lose ? LOST : MOVE;
                end
                MOVE: begin
                    x_ball   <= dx_neg ? x_ball - 8'd1 : x_ball + 8'd1;
                    y_ball   <= dy_neg ? y_ball - 8'd1 : y_ball + 8'd1;
                    moveDone <= 1'b1;
                    state    <= IDLE;
                end
                LOST: if (!gameEnable) begin
                    x_ball   <= 8'(X_START);
                    y_ball   <= 8'(Y_START);
                    dx_neg   <= 1'b0;
                    dy_neg   <= 1'b1;
                    ballLost <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ball_motion.md
# ball_motion

Ball motion controller for the Arkanoid datapath, sitting directly upstream of the level/brick collision stage. Once per frame tick it runs a collision-check handshake with the level stage at the current ball position. It then applies the brick reflection, followed by wall and paddle reflection, and steps the ball one pixel per axis. It produces `x_ball`/`y_ball` for the collision and draw stages and flags a lost ball.

## Interface
Parameters:
- `X_MIN`, 0: left playfield bound (pixels)
- `X_MAX`, 159: right playfield bound
- `Y_MIN`, 0: top playfield bound
- `Y_MAX`, 119: bottom bound; reaching it is a lost ball
- `X_START`, 80: ball x after reset or relaunch
- `Y_START`, 100: ball y after reset or relaunch
- `PADDLE_Y`, 110: paddle top row
- `PADDLE_W`, 16: paddle width (pixels)
- `CHECK_TIMEOUT`, 255: maximum number of cycles spent in CHECK

Ports:
- `clk`, in, 1: system clock (one clock domain)
- `reset`, in, 1: asynchronous, active-low reset
- `frameTick`, in, 1: one-cycle pulse requesting one motion step
- `gameEnable`, in, 1: run enable; low in LOST relaunches the ball
- `x_paddle`, in, 8: paddle left edge
- `ballcheckReset`, out, 1: one-cycle restart pulse to the collision checker
- `ballcheckEnable`, out, 1: collision checker enable, held high through CHECK
- `ballcheckEnd`, in, 1: collision checker finished
- `brickBallCollide`, in, 1: brick hit reported during CHECK
- `collideDir`, in, 3: side of the brick that was hit; 1 = top, 2 = bottom, 3 = left, 4 = right, 5–7 = corner, 0 = none
- `x_ball`, out, 8: ball x position
- `y_ball`, out, 8: ball y position
- `moveDone`, out, 1: one-cycle pulse when the new position is valid
- `ballLost`, out, 1: level signal, high while in LOST

## Operation
- Direction state: `dxNeg`, `dyNeg` (1 = decreasing coordinate). Speed is 1 pixel per axis per step.
- Reset values: `x_ball` = X_START, `y_ball` = Y_START, `dxNeg` = 0, `dyNeg` = 1, state IDLE. All outputs are 0 except `x_ball`/`y_ball`.
- States and transitions:
  - IDLE: on `frameTick` && `gameEnable`, go to CRST. A `frameTick` in any other state is dropped (not queued).
  - CRST: `ballcheckReset` = 1 for one cycle, then go to CHECK. The hit flag is cleared here.
  - CHECK: `ballcheckEnable` = 1. The first cycle in which `brickBallCollide` = 1 sets the hit flag and latches `collideDir`; later hits in the same CHECK are ignored. Leave for REFLECT on the first cycle `ballcheckEnd` = 1, or after CHECK_TIMEOUT cycles (treated as no hit).
  - REFLECT: one cycle, two steps applied in order.
    - Step 1, brick: if hit, dir 1/2 toggles `dyNeg`, dir 3/4 toggles `dxNeg`, dir 5–7 toggles both.
    - Step 2, walls/paddle (these force a direction, never toggle):
      - x == X_MIN forces `dxNeg` = 0; x == X_MAX forces `dxNeg` = 1.
      - y == Y_MIN forces `dyNeg` = 0.
      - `!dyNeg` && y+1 == PADDLE_Y && x_paddle ≤ x ≤ x_paddle+PADDLE_W−1 forces `dyNeg` = 1. The comparison uses 9-bit arithmetic so the sum cannot wrap.
    - Exit: if `!dyNeg` after step 2 and y == Y_MAX−1, go to LOST; otherwise go to MOVE.
  - MOVE: x ± 1 and y ± 1 per direction, then go to IDLE. The result never leaves [X_MIN, X_MAX] × [Y_MIN, Y_MAX−1].
  - LOST: `ballLost` = 1 and position is held. When `gameEnable` = 0, reload X_START/Y_START, set `dxNeg` = 0 and `dyNeg` = 1, and go to IDLE.
- `gameEnable` falling outside LOST: the current step completes, and IDLE then ignores ticks.
- Reset asserted mid-operation: immediate return to the reset values. `ballcheckEnable` and `ballcheckReset` drop asynchronously.

## Timing
- `frameTick` sampled at edge 0 → CRST in cycle 1 → CHECK from cycle 2.
- If `ballcheckEnd` is high in the first CHECK cycle: REFLECT is cycle 3, MOVE is cycle 4, and the new `x_ball`/`y_ball` plus `moveDone` are visible in cycle 5. Minimum latency is 5 cycles.
- Every extra CHECK cycle adds 1. The maximum latency is 4 + CHECK_TIMEOUT.
- `moveDone` is registered and coincides with the first cycle the updated position is visible.
- `ballLost` rises in the cycle after REFLECT, and `moveDone` does not pulse for that step.
- Position outputs are registered and change only at MOVE completion or the LOST relaunch.

## Test plan
- Reset, then one tick with `ballcheckEnd` returned in the first CHECK cycle → `ballcheckReset` 1 cycle, `ballcheckEnable` 1 cycle, x = 81, y = 99, `moveDone` in cycle 5.
- Ball at (100, 50) moving up/right; during CHECK `brickBallCollide` = 1 with `collideDir` = 2, and `ballcheckEnd` after 3 cycles → y = 51, x = 101, latency 7 cycles.
- Ball at (159, 0) moving up/right with no hit → forced to down/left, next position (158, 1).
- Ball at (50, 109) moving down, `x_paddle` = 40 → position (51, 108) moving up. Repeat with `x_paddle` = 60 → after the step to Y_MAX−1, the next REFLECT enters LOST, `ballLost` = 1 and no `moveDone`. Then `gameEnable` = 0 → position (80, 100), `ballLost` = 0.
- `ballcheckEnd` never asserted → leaves CHECK after 255 cycles and moves as if no hit. A second `frameTick` during CHECK is dropped, so exactly one `moveDone` is produced.
- `reset` pulled low during CHECK → `ballcheckEnable` drops within the same cycle, position returns to (80, 100), state IDLE.
